// File: rtl/dot_scan_pkg.sv
// ============================================================================
// Module      : dot_scan_pkg
// Description : Shared types and width helpers for the dot scan sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dot_scan_pkg;

  localparam int c_MIN_W = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic {
    ORDER_ROW = 1'b0,
    ORDER_COL = 1'b1
  } scan_order_e;

  // Index width that never collapses to zero for single-entry ranges.
  function automatic int idx_w(input int n);
    return (n <= 1) ? c_MIN_W : $clog2(n);
  endfunction

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int slice_cnt(input int cols, input int dots, input int dw);
    return (max_i(cols, dots) + dw - 1) / dw;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dot_scan_sequencer_if.sv
// ============================================================================
// Module      : dot_scan_sequencer_if
// Description : Host write bus, scan control and firing outputs bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dot_scan_sequencer_if
  import dot_scan_pkg::*;
#(
  parameter int ROWS   = 48,
  parameter int COLS   = 48,
  parameter int DOTS   = 48,
  parameter int DATA_W = 16,
  parameter int TIME_W = 8
);

  localparam int c_row_w = idx_w(ROWS);
  localparam int c_col_w = idx_w(COLS);
  localparam int c_dot_w = idx_w(DOTS);
  localparam int c_lut_w = idx_w(max_i(ROWS, COLS));
  localparam int c_sl_w  = idx_w(slice_cnt(COLS, DOTS, DATA_W));

  logic               mem_write_n;
  logic [c_row_w-1:0] mem_address;
  logic [c_sl_w-1:0]  mask_select;
  logic [DATA_W-1:0]  mem_data;
  logic               mem_dot_write_n;
  logic [DATA_W-1:0]  mem_dot_data;
  logic               mem_sel_write_n;
  logic [c_lut_w-1:0] mem_sel_address;
  logic [c_dot_w-1:0] mem_sel_data;
  logic               row_col_select;
  logic               col_major;
  logic               loop_en;
  logic [TIME_W-1:0]  fire_len;
  logic [TIME_W-1:0]  gap_len;
  logic               start;
  logic               stop;
  logic               firing_bit;
  logic               firing_data;
  logic [c_row_w-1:0] cur_row;
  logic [c_col_w-1:0] cur_col;
  logic               busy;
  logic               done;

  modport master (
    output mem_write_n, mem_address, mask_select, mem_data,
    output mem_dot_write_n, mem_dot_data,
    output mem_sel_write_n, mem_sel_address, mem_sel_data,
    output row_col_select, col_major, loop_en, fire_len, gap_len, start, stop,
    input  firing_bit, firing_data, cur_row, cur_col, busy, done
  );

  modport slave (
    input  mem_write_n, mem_address, mask_select, mem_data,
    input  mem_dot_write_n, mem_dot_data,
    input  mem_sel_write_n, mem_sel_address, mem_sel_data,
    input  row_col_select, col_major, loop_en, fire_len, gap_len, start, stop,
    output firing_bit, firing_data, cur_row, cur_col, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/dot_scan_index_gen.sv
// ============================================================================
// Module      : dot_scan_index_gen
// Description : Row/column scan counters with order-dependent advance and wrap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dot_scan_index_gen
  import dot_scan_pkg::*;
#(
  parameter int ROWS = 48,
  parameter int COLS = 48
) (
  input  wire logic                     clock,
  input  wire logic                     reset_n,
  input  wire logic                     clear_i,
  input  wire logic                     restart_i,
  input  wire logic                     step_i,
  input  wire logic                     col_major_i,
  output logic      [idx_w(ROWS)-1:0]   row_o,
  output logic      [idx_w(COLS)-1:0]   col_o,
  output logic      [idx_w(ROWS)-1:0]   nxt_row_o,
  output logic      [idx_w(COLS)-1:0]   nxt_col_o,
  output logic                          last_o
);

  localparam int c_row_w = idx_w(ROWS);
  localparam int c_col_w = idx_w(COLS);
  localparam logic [c_row_w-1:0] c_row_last = c_row_w'(ROWS - 1);
  localparam logic [c_col_w-1:0] c_col_last = c_col_w'(COLS - 1);

  logic [c_row_w-1:0] row_q, row_d;
  logic [c_col_w-1:0] col_q, col_d;
  scan_order_e        order_q, order_d;
  logic               w_row_end;
  logic               w_col_end;

  assign w_row_end = (row_q == c_row_last);
  assign w_col_end = (col_q == c_col_last);
  assign last_o    = w_row_end && w_col_end;

  // The cell after the last one is (0,0) so looping needs no special case.
  always_comb begin
    nxt_row_o = row_q;
    nxt_col_o = col_q;
    if (last_o) begin
      nxt_row_o = '0;
      nxt_col_o = '0;
    end else if (order_q == ORDER_ROW) begin
      if (w_col_end) begin
        nxt_col_o = '0;
        nxt_row_o = row_q + 1'b1;
      end else begin
        nxt_col_o = col_q + 1'b1;
      end
    end else begin
      if (w_row_end) begin
        nxt_row_o = '0;
        nxt_col_o = col_q + 1'b1;
      end else begin
        nxt_row_o = row_q + 1'b1;
      end
    end
  end

  always_comb begin
    row_d   = row_q;
    col_d   = col_q;
    order_d = order_q;
    if (clear_i) begin
      row_d = '0;
      col_d = '0;
    end else if (restart_i) begin
      row_d   = '0;
      col_d   = '0;
      order_d = col_major_i ? ORDER_COL : ORDER_ROW;
    end else if (step_i) begin
      row_d = nxt_row_o;
      col_d = nxt_col_o;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row_q   <= '0;
      col_q   <= '0;
      order_q <= ORDER_ROW;
    end else begin
      row_q   <= row_d;
      col_q   <= col_d;
      order_q <= order_d;
    end
  end

  assign row_o = row_q;
  assign col_o = col_q;

endmodule

`default_nettype wire

// File: rtl/dot_scan_sequencer.sv
// ============================================================================
// Module      : dot_scan_sequencer
// Description : Pattern/LUT/dot storage plus autonomous fire/gap scan engine.
//               Build option DOT_SCAN_SKIP_ZERO_EN: zero cells take one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dot_scan_sequencer
  import dot_scan_pkg::*;
#(
  parameter int ROWS   = 48,
  parameter int COLS   = 48,
  parameter int DOTS   = 48,
  parameter int DATA_W = 16,
  parameter int TIME_W = 8
) (
  input wire logic            clock,
  input wire logic            reset_n,
  dot_scan_sequencer_if.slave bus
);

  localparam int c_row_w  = idx_w(ROWS);
  localparam int c_col_w  = idx_w(COLS);
  localparam int c_dot_w  = idx_w(DOTS);
  localparam int c_lut_n  = max_i(ROWS, COLS);
  localparam int c_lut_w  = idx_w(c_lut_n);
  localparam int c_slices = slice_cnt(COLS, DOTS, DATA_W);
  localparam int c_sl_w   = idx_w(c_slices);

`ifdef DOT_SCAN_SKIP_ZERO_EN
  localparam bit c_skip_zero = 1'b1;
`else
  localparam bit c_skip_zero = 1'b0;
`endif

  logic [COLS-1:0]    pat_q [ROWS];
  logic [DOTS-1:0]    dot_q;
  logic [c_dot_w-1:0] lut_q [c_lut_n];

  logic [COLS-1:0] w_pat_mask, w_pat_wdata;
  logic [DOTS-1:0] w_dot_mask, w_dot_wdata;
  logic            w_slice_ok, w_pat_we, w_dot_we, w_lut_we;

  for (genvar c = 0; c < COLS; c++) begin : g_pat_bit
    localparam logic [c_sl_w-1:0] c_sl = c_sl_w'(c / DATA_W);
    assign w_pat_mask[c]  = (bus.mask_select == c_sl);
    assign w_pat_wdata[c] = bus.mem_data[c % DATA_W];
  end

  for (genvar d = 0; d < DOTS; d++) begin : g_dot_bit
    localparam logic [c_sl_w-1:0] c_sl = c_sl_w'(d / DATA_W);
    assign w_dot_mask[d]  = (bus.mask_select == c_sl);
    assign w_dot_wdata[d] = bus.mem_dot_data[d % DATA_W];
  end

  assign w_slice_ok = (int'(bus.mask_select) < c_slices);
  assign w_pat_we   = !bus.mem_write_n && w_slice_ok && (int'(bus.mem_address) < ROWS);
  assign w_dot_we   = !bus.mem_dot_write_n && w_slice_ok;
  assign w_lut_we   = !bus.mem_sel_write_n && (int'(bus.mem_sel_address) < c_lut_n)
                      && (int'(bus.mem_sel_data) < DOTS);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < ROWS; r++) pat_q[r] <= '0;
      for (int l = 0; l < c_lut_n; l++) lut_q[l] <= '0;
      dot_q <= '0;
    end else begin
      if (w_pat_we)
        pat_q[bus.mem_address] <= (pat_q[bus.mem_address] & ~w_pat_mask)
                                  | (w_pat_wdata & w_pat_mask);
      if (w_dot_we)
        dot_q <= (dot_q & ~w_dot_mask) | (w_dot_wdata & w_dot_mask);
      if (w_lut_we)
        lut_q[bus.mem_sel_address] <= bus.mem_sel_data;
    end
  end

  logic               w_clear, w_restart, w_step, w_last;
  logic [c_row_w-1:0] w_row, w_nxt_row;
  logic [c_col_w-1:0] w_col, w_nxt_col;

  dot_scan_index_gen #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_index_gen (
    .clock       (clock),
    .reset_n     (reset_n),
    .clear_i     (w_clear),
    .restart_i   (w_restart),
    .step_i      (w_step),
    .col_major_i (bus.col_major),
    .row_o       (w_row),
    .col_o       (w_col),
    .nxt_row_o   (w_nxt_row),
    .nxt_col_o   (w_nxt_col),
    .last_o      (w_last)
  );

  // Both candidate cells are read independently of the FSM so that the
  // load decision never feeds back into its own read address.
  logic               w_first_bit, w_first_dot, w_nxt_bit, w_nxt_dot;
  logic [c_lut_w-1:0] w_nxt_lut_idx;
  logic [c_dot_w-1:0] w_first_lut, w_nxt_lut;

  assign w_first_bit   = pat_q[0][0];
  assign w_first_lut   = lut_q[0];
  assign w_first_dot   = (int'(w_first_lut) < DOTS) ? dot_q[w_first_lut] : 1'b0;
  assign w_nxt_bit     = pat_q[w_nxt_row][w_nxt_col];
  assign w_nxt_lut_idx = bus.row_col_select ? c_lut_w'(w_nxt_col) : c_lut_w'(w_nxt_row);
  assign w_nxt_lut     = lut_q[w_nxt_lut_idx];
  assign w_nxt_dot     = (int'(w_nxt_lut) < DOTS) ? dot_q[w_nxt_lut] : 1'b0;

  function automatic logic [TIME_W-1:0] fire_dwell(input logic cell_v,
                                                   input logic [TIME_W-1:0] len);
    if (c_skip_zero && !cell_v) return '0;
    return (len == '0) ? '0 : len - 1'b1;
  endfunction

  state_e            state_q, state_d;
  logic [TIME_W-1:0] dwell_q, dwell_d;
  logic              cell_bit_q, cell_bit_d, cell_dot_q, cell_dot_d;
  logic              firing_bit_q, firing_bit_d, firing_data_q, firing_data_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              w_adv;

  always_comb begin
    state_d    = state_q;
    dwell_d    = dwell_q;
    cell_bit_d = cell_bit_q;
    cell_dot_d = cell_dot_q;
    w_clear    = 1'b0;
    w_restart  = 1'b0;
    w_step     = 1'b0;
    w_adv      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.stop) begin
          w_restart  = 1'b1;
          state_d    = ST_FIRE;
          cell_bit_d = w_first_bit;
          cell_dot_d = w_first_dot;
          dwell_d    = fire_dwell(w_first_bit, bus.fire_len);
        end
      end
      ST_FIRE: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
          w_clear = 1'b1;
        end else if (dwell_q != '0) begin
          dwell_d = dwell_q - 1'b1;
        end else if ((bus.gap_len != '0) && (cell_bit_q || !c_skip_zero)) begin
          state_d = ST_GAP;
          dwell_d = bus.gap_len - 1'b1;
        end else begin
          w_adv = 1'b1;
        end
      end
      ST_GAP: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
          w_clear = 1'b1;
        end else if (dwell_q != '0) begin
          dwell_d = dwell_q - 1'b1;
        end else begin
          w_adv = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        w_clear = bus.stop;
      end
      default: state_d = ST_IDLE;
    endcase

    if (w_adv) begin
      if (w_last && !bus.loop_en) begin
        state_d = ST_DONE;
      end else begin
        w_step     = 1'b1;
        state_d    = ST_FIRE;
        cell_bit_d = w_nxt_bit;
        cell_dot_d = w_nxt_dot;
        dwell_d    = fire_dwell(w_nxt_bit, bus.fire_len);
      end
    end

    firing_bit_d  = (state_d == ST_FIRE) && cell_bit_d;
    firing_data_d = (state_d == ST_FIRE) && cell_dot_d;
    busy_d        = (state_d == ST_FIRE) || (state_d == ST_GAP);
    done_d        = (state_d == ST_DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      dwell_q       <= '0;
      cell_bit_q    <= 1'b0;
      cell_dot_q    <= 1'b0;
      firing_bit_q  <= 1'b0;
      firing_data_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      dwell_q       <= dwell_d;
      cell_bit_q    <= cell_bit_d;
      cell_dot_q    <= cell_dot_d;
      firing_bit_q  <= firing_bit_d;
      firing_data_q <= firing_data_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign bus.firing_bit  = firing_bit_q;
  assign bus.firing_data = firing_data_q;
  assign bus.cur_row     = w_row;
  assign bus.cur_col     = w_col;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

`default_nettype wire

// File: tb/tb_dot_scan_sequencer.sv
// ============================================================================
// Module      : tb_dot_scan_sequencer
// Description : Self-checking bench for a 4x4 build against a trace model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dot_scan_sequencer;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int DOTS   = 5;
  localparam int DATA_W = 2;
  localparam int TIME_W = 4;
  localparam int NSL    = 3;
  localparam int NLUT   = 4;
`ifdef DOT_SCAN_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  dot_scan_sequencer_if #(.ROWS(ROWS), .COLS(COLS), .DOTS(DOTS),
                          .DATA_W(DATA_W), .TIME_W(TIME_W)) bus ();

  dot_scan_sequencer #(.ROWS(ROWS), .COLS(COLS), .DOTS(DOTS),
                       .DATA_W(DATA_W), .TIME_W(TIME_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  // Reference storage, updated by the host write tasks.
  bit         m_pat [ROWS][COLS];
  bit         m_dot [DOTS];
  int         m_lut [NLUT];
  logic [7:0] exp_q [$];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] pack(bit b, bit d, int r, int c, bit bz, bit dn);
    logic [1:0] rr, cc;
    rr = r[1:0];
    cc = c[1:0];
    return {b, d, rr, cc, bz, dn};
  endfunction

  function automatic logic [7:0] obs();
    return {bus.firing_bit, bus.firing_data, bus.cur_row, bus.cur_col, bus.busy, bus.done};
  endfunction

  function automatic bit exp_dot(int li);
    return (m_lut[li] < DOTS) ? m_dot[m_lut[li]] : 1'b0;
  endfunction

  function automatic void mdl_pat(int a, int s, logic [1:0] dat);
    if (a < ROWS && s < NSL)
      for (int b = 0; b < DATA_W; b++)
        if (s * DATA_W + b < COLS) m_pat[a][s * DATA_W + b] = dat[b];
  endfunction

  function automatic void mdl_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) m_pat[r][c] = 1'b0;
    for (int d = 0; d < DOTS; d++) m_dot[d] = 1'b0;
    for (int l = 0; l < NLUT; l++) m_lut[l] = 0;
  endfunction

  // One expected output word per cycle from the first FIRE cycle to IDLE.
  function automatic void build_trace(bit cm, bit rcs, int fl, int gl);
    int r, c, nf, ng;
    bit b, d;
    exp_q.delete();
    r = 0;
    c = 0;
    for (int k = 0; k < ROWS * COLS; k++) begin
      r  = cm ? k % ROWS : k / COLS;
      c  = cm ? k / ROWS : k % COLS;
      b  = m_pat[r][c];
      d  = exp_dot(rcs ? c : r);
      nf = (fl < 1) ? 1 : fl;
      ng = gl;
      if (SKIP && !b) begin
        nf = 1;
        ng = 0;
      end
      repeat (nf) exp_q.push_back(pack(b, d, r, c, 1'b1, 1'b0));
      repeat (ng) exp_q.push_back(pack(1'b0, 1'b0, r, c, 1'b1, 1'b0));
    end
    exp_q.push_back(pack(1'b0, 1'b0, r, c, 1'b0, 1'b1));
    exp_q.push_back(pack(1'b0, 1'b0, r, c, 1'b0, 1'b0));
  endfunction

  task automatic wr_pat(int a, int s, logic [1:0] dat);
    bus.mem_address = a[1:0];
    bus.mask_select = s[1:0];
    bus.mem_data    = dat;
    bus.mem_write_n = 1'b0;
    tick();
    bus.mem_write_n = 1'b1;
    mdl_pat(a, s, dat);
  endtask

  task automatic wr_dot(int s, logic [1:0] dat);
    bus.mask_select     = s[1:0];
    bus.mem_dot_data    = dat;
    bus.mem_dot_write_n = 1'b0;
    tick();
    bus.mem_dot_write_n = 1'b1;
    if (s < NSL)
      for (int b = 0; b < DATA_W; b++)
        if (s * DATA_W + b < DOTS) m_dot[s * DATA_W + b] = dat[b];
  endtask

  task automatic wr_lut(int a, int v);
    bus.mem_sel_address = a[1:0];
    bus.mem_sel_data    = v[2:0];
    bus.mem_sel_write_n = 1'b0;
    tick();
    bus.mem_sel_write_n = 1'b1;
    if (a < NLUT && v < DOTS) m_lut[a] = v;
  endtask

  task automatic rand_pattern();
    for (int r = 0; r < ROWS; r++)
      for (int s = 0; s < 2; s++) wr_pat(r, s, 2'($urandom));
  endtask

  task automatic setup(bit cm, bit rcs, int fl, int gl);
    bus.col_major      = cm;
    bus.row_col_select = rcs;
    bus.fire_len       = fl[TIME_W-1:0];
    bus.gap_len        = gl[TIME_W-1:0];
    bus.loop_en        = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (obs() !== 8'h00) begin
      failures++;
      $display("FAIL reset_state got=%b exp=%b", obs(), 8'h00);
    end
    wr_pat(0, 0, 2'b01);
    setup(1'b0, 1'b0, 8, 0);
    pulse_start();
    tick();
    checks++;
    if (obs() !== pack(1'b1, exp_dot(0), 0, 0, 1'b1, 1'b0)) begin
      failures++;
      $display("FAIL mid_fire got=%b exp=%b", obs(), pack(1'b1, exp_dot(0), 0, 0, 1'b1, 1'b0));
    end
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if (obs() !== 8'h00) begin
      failures++;
      $display("FAIL async_reset got=%b exp=%b", obs(), 8'h00);
    end
    #2 reset_n = 1'b1;
    mdl_clear();
    tick();
    setup(1'b0, 1'b0, 1, 1);
    build_trace(1'b0, 1'b0, 1, 1);
    pulse_start();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs() !== exp_q[i]) begin
        failures++;
        $display("FAIL zero_scan cyc=%0d got=%b exp=%b", i, obs(), exp_q[i]);
      end
      tick();
    end
  endtask

  task automatic test_row_major();
    for (int r = 0; r < ROWS; r++) begin
      wr_pat(r, 0, (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : 2'b00);
      wr_pat(r, 1, (r == 2) ? 2'b01 : (r == 3) ? 2'b10 : 2'b00);
    end
    setup(1'b0, 1'b0, 2, 1);
    build_trace(1'b0, 1'b0, 2, 1);
    pulse_start();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs() !== exp_q[i]) begin
        failures++;
        $display("FAIL row_major cyc=%0d got=%b exp=%b", i, obs(), exp_q[i]);
      end
      tick();
    end
  endtask

  task automatic test_col_major_lut();
    for (int c = 0; c < NLUT; c++) wr_lut(c, c);
    wr_dot(0, 2'b10);
    wr_dot(1, 2'b10);
    wr_dot(2, 2'b00);
    rand_pattern();
    setup(1'b1, 1'b1, 1, 0);
    build_trace(1'b1, 1'b1, 1, 0);
    pulse_start();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs() !== exp_q[i]) begin
        failures++;
        $display("FAIL col_major_lut cyc=%0d got=%b exp=%b", i, obs(), exp_q[i]);
      end
      tick();
    end
  endtask

  task automatic test_loop_stop();
    int k, r, c;
    rand_pattern();
    setup(1'b0, 1'b0, 0, 0);
    bus.loop_en = 1'b1;
    pulse_start();
    for (int i = 0; i < 40; i++) begin
      k = i % (ROWS * COLS);
      r = k / COLS;
      c = k % COLS;
      checks++;
      if (obs() !== pack(m_pat[r][c], exp_dot(r), r, c, 1'b1, 1'b0)) begin
        failures++;
        $display("FAIL loop cyc=%0d got=%b exp=%b", i, obs(),
                 pack(m_pat[r][c], exp_dot(r), r, c, 1'b1, 1'b0));
      end
      tick();
    end
    bus.stop = 1'b1;
    tick();
    bus.stop    = 1'b0;
    bus.loop_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs() !== 8'h00) begin
        failures++;
        $display("FAIL stop_idle cyc=%0d got=%b exp=%b", i, obs(), 8'h00);
      end
      tick();
    end
  endtask

  task automatic test_start_stop();
    setup(1'b0, 1'b0, 2, 1);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs() !== 8'h00) begin
        failures++;
        $display("FAIL start_stop cyc=%0d got=%b exp=%b", i, obs(), 8'h00);
      end
      tick();
    end
    build_trace(1'b0, 1'b0, 2, 1);
    pulse_start();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs() !== exp_q[i]) begin
        failures++;
        $display("FAIL start_busy cyc=%0d got=%b exp=%b", i, obs(), exp_q[i]);
      end
      if (i == 5 || i == 20) bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
    end
  endtask

  task automatic test_write_during_scan();
    logic [1:0] dat;
    rand_pattern();
    setup(1'b0, 1'b0, 1, 1);
    dat = {~m_pat[2][3], m_pat[2][2]};
    mdl_pat(2, 1, dat);
    build_trace(1'b0, 1'b0, 1, 1);
    pulse_start();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs() !== exp_q[i]) begin
        failures++;
        $display("FAIL write_mid_scan cyc=%0d got=%b exp=%b", i, obs(), exp_q[i]);
      end
      if (i == 8) begin
        bus.mem_address = 2'd2;
        bus.mask_select = 2'd1;
        bus.mem_data    = dat;
        bus.mem_write_n = 1'b0;
      end
      tick();
      bus.mem_write_n = 1'b1;
    end
    wr_pat(1, 3, 2'b11);
    wr_pat(1, 2, 2'b11);
    wr_lut(0, 6);
    wr_lut(1, 7);
    setup(1'b0, 1'b0, 0, 0);
    build_trace(1'b0, 1'b0, 0, 0);
    pulse_start();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs() !== exp_q[i]) begin
        failures++;
        $display("FAIL oor_write cyc=%0d got=%b exp=%b", i, obs(), exp_q[i]);
      end
      tick();
    end
  endtask

  task automatic test_random();
    int fl, gl;
    bit cm, rcs;
    for (int it = 0; it < 4; it++) begin
      rand_pattern();
      for (int l = 0; l < NLUT; l++) wr_lut(l, $urandom_range(0, 7));
      for (int s = 0; s < 4; s++) wr_dot(s, 2'($urandom));
      cm  = 1'($urandom);
      rcs = 1'($urandom);
      fl  = $urandom_range(0, 3);
      gl  = $urandom_range(0, 2);
      setup(cm, rcs, fl, gl);
      build_trace(cm, rcs, fl, gl);
      pulse_start();
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs() !== exp_q[i]) begin
          failures++;
          $display("FAIL random it=%0d cyc=%0d got=%b exp=%b", it, i, obs(), exp_q[i]);
        end
        tick();
      end
    end
  endtask

  initial begin
    bus.mem_write_n     = 1'b1;
    bus.mem_address     = '0;
    bus.mask_select     = '0;
    bus.mem_data        = '0;
    bus.mem_dot_write_n = 1'b1;
    bus.mem_dot_data    = '0;
    bus.mem_sel_write_n = 1'b1;
    bus.mem_sel_address = '0;
    bus.mem_sel_data    = '0;
    bus.row_col_select  = 1'b0;
    bus.col_major       = 1'b0;
    bus.loop_en         = 1'b0;
    bus.fire_len        = '0;
    bus.gap_len         = '0;
    bus.start           = 1'b0;
    bus.stop            = 1'b0;
    mdl_clear();
    test_reset();
    test_row_major();
    test_col_major_lut();
    test_loop_stop();
    test_start_stop();
    test_write_during_scan();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
